// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: owns the fetch PC and decides each cycle whether
// fetch advances, holds, inserts a bubble or redirects to a resolved branch target.
module fetch_sequencer #(
   parameter int PC_WIDTH   = 16,
   parameter int BR_TIMEOUT = 8
) (
   input  logic                I_CLOCK,
   input  logic                I_RESET_N,
   input  logic                I_LOCK,
   input  logic                I_DepStallSignal,
   input  logic                I_BranchDecoded,
   input  logic                I_BranchResolved,
   input  logic                I_BranchTaken,
   input  logic [PC_WIDTH-1:0] I_BranchPC,
   output logic [PC_WIDTH-1:0] O_FetchPC,
   output logic                O_LatchEn,
   output logic                O_FetchStall,
   output logic [1:0]          O_State,
   output logic                O_Timeout
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      DEP_HOLD = 2'd2,
      BR_WAIT  = 2'd3
   } state_t;

   localparam logic [7:0]          WAIT_LAST = 8'(BR_TIMEOUT - 1);
   localparam logic [PC_WIDTH-1:0] PC_STEP   = PC_WIDTH'(4);

   state_t              state_reg;
   logic [PC_WIDTH-1:0] pc_reg;
   logic [7:0]          wait_cnt_reg;
   logic                timeout_reg;
   logic                taken_resolve;

   assign taken_resolve = I_BranchResolved & I_BranchTaken;

   // State advances on the falling edge so fetch sees a stable PC for the whole high phase.
   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state_reg    <= IDLE;
         pc_reg       <= '0;
         wait_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
      end else if (!I_LOCK) begin
         state_reg    <= IDLE;
         pc_reg       <= '0;
         wait_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg <= RUN;
            end
            RUN: begin
               if (taken_resolve) begin
                  pc_reg <= I_BranchPC;
               end else if (I_DepStallSignal) begin
                  state_reg <= DEP_HOLD;
               end else if (I_BranchDecoded) begin
                  state_reg    <= BR_WAIT;
                  wait_cnt_reg <= '0;
               end else begin
                  pc_reg <= pc_reg + PC_STEP;
               end
            end
            DEP_HOLD: begin
               if (taken_resolve) begin
                  pc_reg    <= I_BranchPC;
                  state_reg <= RUN;
               end else if (!I_DepStallSignal) begin
                  state_reg <= RUN;
               end
            end
            BR_WAIT: begin
               wait_cnt_reg <= wait_cnt_reg + 8'd1;
               // A not-taken resolve keeps the PC: it already points past the branch.
               if (I_BranchResolved) begin
                  if (I_BranchTaken) begin
                     pc_reg <= I_BranchPC;
                  end
                  state_reg <= RUN;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  timeout_reg <= 1'b1;
                  state_reg   <= RUN;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      O_LatchEn    = 1'b0;
      O_FetchStall = 1'b1;
      case (state_reg)
         IDLE: begin
            O_LatchEn    = 1'b0;
            O_FetchStall = 1'b1;
         end
         RUN: begin
            O_LatchEn    = 1'b1;
            O_FetchStall = 1'b0;
            if (!taken_resolve) begin
               if (I_DepStallSignal) begin
                  O_LatchEn = 1'b0;
               end else if (I_BranchDecoded) begin
                  O_FetchStall = 1'b1;
               end
            end
         end
         DEP_HOLD: begin
            O_LatchEn    = 1'b0;
            O_FetchStall = 1'b0;
         end
         BR_WAIT: begin
            O_LatchEn    = 1'b1;
            O_FetchStall = 1'b1;
         end
         default: begin
            O_LatchEn    = 1'b0;
            O_FetchStall = 1'b1;
         end
      endcase
   end

   assign O_FetchPC = pc_reg;
   assign O_State   = state_reg;
   assign O_Timeout = timeout_reg;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM that owns the fetch program counter and the FE/DE latch enable. It turns decode-stage dependency stalls, branch-decode notifications and memory-stage branch resolutions into one consistent per-cycle fetch action: advance, hold, bubble or redirect. It sits between the decode/memory hazard logic and the instruction-memory read port of the fetch stage. It replaces the ad-hoc stall bookkeeping inside fetch with an explicit, verifiable state machine.

## Interface
- PC_WIDTH, 16, width of fetch PC and branch target
- BR_TIMEOUT, 8, maximum BR_WAIT cycles before forced recovery (range 2..255)

- I_CLOCK  in  1  clock; all state updates on negedge
- I_RESET_N  in  1  reset, asynchronous and active-low
- I_LOCK  in  1  pipeline enable from the high-level module; 0 forces IDLE
- I_DepStallSignal  in  1  decode detected a register dependency this cycle
- I_BranchDecoded  in  1  decode holds a branch this cycle (one-cycle pulse)
- I_BranchResolved  in  1  memory stage resolved a branch this cycle (one-cycle pulse)
- I_BranchTaken  in  1  valid with I_BranchResolved; 1 = redirect
- I_BranchPC  in  PC_WIDTH  branch target; valid with I_BranchResolved
- O_FetchPC  out  PC_WIDTH  byte address fetch reads this cycle (word index = O_FetchPC[PC_WIDTH-1:2])
- O_LatchEn  out  1  FE/DE latch update enable (combinational)
- O_FetchStall  out  1  latched instruction is a bubble (combinational)
- O_State  out  2  IDLE=0, RUN=1, DEP_HOLD=2, BR_WAIT=3
- O_Timeout  out  1  sticky: a BR_WAIT exceeded BR_TIMEOUT

## Operation
- Registers: state, O_FetchPC, wait counter (8 bits), O_Timeout.
- IDLE: O_LatchEn=0, O_FetchStall=1, O_FetchPC held at 0. I_LOCK=1 -> RUN.
- RUN: default O_LatchEn=1, O_FetchStall=0, PC <= PC+4.
  - I_DepStallSignal=1: O_LatchEn=0, PC held, -> DEP_HOLD. Takes priority over I_BranchDecoded.
  - else I_BranchDecoded=1: O_LatchEn=1, O_FetchStall=1 (the fetched slot is a bubble), PC held, counter cleared, -> BR_WAIT.
- DEP_HOLD: O_LatchEn=0, O_FetchStall=0, PC held. -> RUN when I_DepStallSignal=0. A branch stalled in decode reaches BR_WAIT through RUN.
- BR_WAIT: O_LatchEn=1, O_FetchStall=1, PC held, counter +1 per cycle.
  - I_BranchResolved & I_BranchTaken: PC <= I_BranchPC, -> RUN.
  - I_BranchResolved & !I_BranchTaken: PC unchanged (already branch+4), -> RUN.
  - counter==BR_TIMEOUT-1 with no resolve: O_Timeout <= 1, -> RUN, PC unchanged.
- A resolve with I_BranchTaken=1 in RUN or DEP_HOLD redirects: PC <= I_BranchPC, -> RUN, and it overrides a simultaneous I_DepStallSignal or I_BranchDecoded. A not-taken resolve outside BR_WAIT has no effect.
- Any state with I_LOCK=0 -> IDLE, PC <= 0, counter <= 0. O_Timeout is retained.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFFFC+4 = 0x0000. Bits [1:0] of I_BranchPC are stored as given.

## Timing
- Reset (I_RESET_N=0, immediately, independent of the clock): state=IDLE, O_FetchPC=0, counter=0, O_Timeout=0. This yields O_LatchEn=0, O_FetchStall=1, O_State=0.
- Deassertion takes effect at the first negedge with I_RESET_N=1. Reset asserted mid-branch discards all pending state.
- O_LatchEn and O_FetchStall are combinational from state and the current-cycle inputs. All other outputs change only on negedge.
- Redirect latency: resolve sampled at negedge N; the target is on O_FetchPC after N and is latched at negedge N+1.
- Minimum BR_WAIT occupancy: 1 cycle. The timeout fires on BR_WAIT cycle BR_TIMEOUT.
- Simultaneous-input priority: I_LOCK=0 > taken resolve > I_DepStallSignal > I_BranchDecoded.

## Test plan
- Reset, then I_LOCK=1 for 4 cycles, no hazards -> O_FetchPC sequence 0,4,8,12,16; O_LatchEn=1; O_FetchStall=0 from the first RUN cycle.
- At PC=8, I_DepStallSignal=1 for 3 cycles -> O_LatchEn=0 and PC held at 8 for 3 cycles; then RUN resumes at 8, 12.
- At PC=12, I_BranchDecoded, then 2 cycles later resolve taken with I_BranchPC=0x40 -> 3 bubble cycles (O_FetchStall=1), then O_FetchPC=0x40, 0x44.
- Same sequence with a not-taken resolve -> O_FetchPC stays 12 through BR_WAIT, then 12, 16.
- BR_TIMEOUT=4, branch decoded and never resolved -> after 4 BR_WAIT cycles O_Timeout=1 and state=RUN. O_Timeout stays 1 after I_LOCK toggles and clears only on I_RESET_N=0.
- Taken resolve coincident with I_DepStallSignal=1 in RUN -> next O_FetchPC=I_BranchPC, state RUN. I_RESET_N pulsed low mid-BR_WAIT -> immediately O_FetchPC=0, O_State=0.
